instruction_buffer_mc: RTL and testbench
========================================

INSTRUCTION_BUFFER_MC -- requirements
Module: instruction_buffer_mc

Interface
REQ-001 SHALL have parameter NUM_CH, default 4, number of independent warp instruction queues (>=1).
REQ-002 SHALL have parameter DEPTH, default 8, entries per queue (power of two, >=2).
REQ-003 SHALL have parameter DATA_WIDTH, default 32, instruction word width.
REQ-004 SHALL have parameter AFULL_THRESH, default DEPTH-2, almost-full level (1..DEPTH).
REQ-005 SHALL have port clk  input  1  rising-edge clock.
REQ-006 SHALL have port rst_n  input  1  asynchronous, active-low reset.
REQ-007 SHALL have port push_valid  input  1  write request.
REQ-008 SHALL have port push_ch  input  clog2(NUM_CH) (min 1)  target queue of write.
REQ-009 SHALL have port push_data  input  DATA_WIDTH  instruction to write.
REQ-010 SHALL have port push_ready  output  1  target queue can accept write.
REQ-011 SHALL have port pop  input  NUM_CH  per-queue read-advance request.
REQ-012 SHALL have port flush  input  NUM_CH  per-queue discard-all request.
REQ-013 SHALL have port out_data  output  NUM_CH*DATA_WIDTH  head instruction per queue, queue i at bits [i*DATA_WIDTH +: DATA_WIDTH].
REQ-014 SHALL have port out_valid  output  NUM_CH  queue i non-empty.
REQ-015 SHALL have port count  output  NUM_CH*(clog2(DEPTH)+1)  occupancy per queue, same packing as out_data.
REQ-016 SHALL have port almost_full  output  NUM_CH  count[i] >= AFULL_THRESH.
REQ-017 SHALL have port full  output  NUM_CH  count[i] == DEPTH.
REQ-018 SHALL have port overflow_err  output  1  sticky: push attempted to full queue.
REQ-019 SHALL have port underflow_err  output  1  sticky: pop attempted on empty queue.

Function
REQ-020 Each queue SHALL be a circular buffer with own write pointer, read pointer, count; pointers wrap DEPTH-1 -> 0.
REQ-021 push_ready SHALL equal !full[push_ch], combinational; push_ch >= NUM_CH -> push_ready=0, write dropped, overflow_err set.
REQ-022 Write accepted when push_valid && push_ready && !flush[push_ch]; stored at write pointer, pointer +1, count +1.
REQ-023 Push to a full queue SHALL be rejected even if same-cycle pop on that queue; overflow_err set next cycle.
REQ-024 pop[i] with out_valid[i]=1 SHALL advance read pointer i, count -1; pop[i] on empty queue ignored, underflow_err set.
REQ-025 Simultaneous accepted push and pop on same queue SHALL leave count unchanged, both pointers advance.
REQ-026 Read SHALL be first-word fall-through: out_data slice i = entry at read pointer i, combinational, zero latency.
REQ-027 out_data slice i SHALL be all zeros when out_valid[i]=0.
REQ-028 Written word SHALL appear on out_data the cycle after acceptance into an empty queue.
REQ-029 flush[i] SHALL zero pointers and count of queue i next cycle, priority over same-cycle push/pop on i; discarded push/pop set no error flag.
REQ-030 Queues SHALL be fully independent; activity on queue i never alters state of queue j.
REQ-031 overflow_err and underflow_err SHALL hold once set until reset; flush does not clear them.
REQ-032 Storage array SHALL not be reset; only pointers, counts, error flags reset.

Reset
REQ-033 On rst_n low, asynchronously: all pointers/counts 0, out_valid=0, full=0, almost_full=0 (AFULL_THRESH>=1), out_data=0, push_ready=1 for valid push_ch, error flags 0.
REQ-034 Reset mid-operation SHALL discard all queued entries; first post-reset write to any queue is its head.

Verification (NUM_CH=4, DEPTH=4, DATA_WIDTH=32, AFULL_THRESH=3)
REQ-035 Push 0xA0..0xA3 to ch2, pop ch2 four cycles -> out_data[2] 0xA0,0xA1,0xA2,0xA3; count[2] 4->0; other queues out_valid=0.
REQ-036 Fill ch1 (4 pushes), then push 0xFF with pop[1]=1 -> push_ready=0, 0xFF dropped, count[1]=3, overflow_err=1.
REQ-037 ch0 count=2, same-cycle push 0xB0 and pop -> count[0] stays 2, head advances; wrap across 6 cycles keeps FIFO order.
REQ-038 ch3 holds 3 entries, flush[3] with push_valid to ch3 -> next cycle count[3]=0, out_data[3]=0, overflow_err unchanged.
REQ-039 pop[0] on empty ch0 -> underflow_err=1, count[0]=0; stays 1 after flush, clears only on rst_n.
REQ-040 Assert rst_n low with all queues holding 2 entries -> all counts 0, out_valid=4'b0000 immediately, no clock edge needed.

Source files
------------

// File: rtl/instruction_buffer_mc_if.sv
// Handshake bundle for the multi-channel instruction buffer:
// one shared push port, per-queue pop/flush and head/status outputs.
interface instruction_buffer_mc_if #(
  parameter int NUM_CH     = 4,
  parameter int DEPTH      = 8,
  parameter int DATA_WIDTH = 32
);
  localparam int CW   = (NUM_CH > 1) ? $clog2(NUM_CH) : 1;
  localparam int CNTW = $clog2(DEPTH) + 1;

  logic                         push_valid;
  logic [CW-1:0]                push_ch;
  logic [DATA_WIDTH-1:0]        push_data;
  logic                         push_ready;
  logic [NUM_CH-1:0]            pop;
  logic [NUM_CH-1:0]            flush;
  logic [NUM_CH*DATA_WIDTH-1:0] out_data;
  logic [NUM_CH-1:0]            out_valid;
  logic [NUM_CH*CNTW-1:0]       count;
  logic [NUM_CH-1:0]            almost_full;
  logic [NUM_CH-1:0]            full;
  logic                         overflow_err;
  logic                         underflow_err;

  modport master (
    output push_valid, push_ch, push_data,
    output pop, flush,
    input  push_ready, out_data, out_valid,
    input  count, almost_full, full,
    input  overflow_err, underflow_err
  );

  modport slave (
    input  push_valid, push_ch, push_data,
    input  pop, flush,
    output push_ready, out_data, out_valid,
    output count, almost_full, full,
    output overflow_err, underflow_err
  );
endinterface

// File: rtl/instruction_buffer_mc.sv
// Per-warp instruction queues: NUM_CH independent circular FIFOs
// with first-word fall-through heads, shared push port, sticky errors.
module instruction_buffer_mc #(
  parameter int NUM_CH       = 4,
  parameter int DEPTH        = 8,
  parameter int DATA_WIDTH   = 32,
  parameter int AFULL_THRESH = DEPTH - 2
) (
  input  logic clk,
  input  logic rst_n,
  instruction_buffer_mc_if.slave bus
);
  localparam int CW   = (NUM_CH > 1) ? $clog2(NUM_CH) : 1;
  localparam int AW   = $clog2(DEPTH);
  localparam int CNTW = AW + 1;

  logic [DATA_WIDTH-1:0] mem_q [NUM_CH][DEPTH];

  logic [AW-1:0]   wr_ptr_q [NUM_CH];
  logic [AW-1:0]   wr_ptr_d [NUM_CH];
  logic [AW-1:0]   rd_ptr_q [NUM_CH];
  logic [AW-1:0]   rd_ptr_d [NUM_CH];
  logic [CNTW-1:0] cnt_q    [NUM_CH];
  logic [CNTW-1:0] cnt_d    [NUM_CH];
  logic            ovf_q, ovf_d;
  logic            unf_q, unf_d;

  logic              ch_ok;
  logic [NUM_CH-1:0] sel;
  logic [NUM_CH-1:0] full_w;
  logic [NUM_CH-1:0] empty_w;
  logic [NUM_CH-1:0] wr_en;
  logic [NUM_CH-1:0] rd_en;

  always_comb begin
    ch_ok = 32'(bus.push_ch) < NUM_CH;
    for (int i = 0; i < NUM_CH; i++) begin
      sel[i]     = ch_ok && (bus.push_ch == CW'(i));
      full_w[i]  = cnt_q[i] == CNTW'(DEPTH);
      empty_w[i] = cnt_q[i] == '0;
    end
  end

  assign bus.push_ready = ch_ok && |(sel & ~full_w);

  // Flush wins over push/pop and suppresses their error reporting.
  always_comb begin
    for (int i = 0; i < NUM_CH; i++) begin
      wr_en[i] = sel[i] && bus.push_valid && !full_w[i]
                 && !bus.flush[i];
      rd_en[i] = bus.pop[i] && !empty_w[i] && !bus.flush[i];
      if (bus.flush[i]) begin
        wr_ptr_d[i] = '0;
        rd_ptr_d[i] = '0;
        cnt_d[i]    = '0;
      end else begin
        wr_ptr_d[i] = wr_ptr_q[i] + AW'(wr_en[i]);
        rd_ptr_d[i] = rd_ptr_q[i] + AW'(rd_en[i]);
        cnt_d[i]    = cnt_q[i] + CNTW'(wr_en[i])
                      - CNTW'(rd_en[i]);
      end
    end
    ovf_d = ovf_q | (bus.push_valid && !bus.push_ready
                     && !(|(sel & bus.flush)));
    unf_d = unf_q | (|(bus.pop & empty_w & ~bus.flush));
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int i = 0; i < NUM_CH; i++) begin
        wr_ptr_q[i] <= '0;
        rd_ptr_q[i] <= '0;
        cnt_q[i]    <= '0;
      end
      ovf_q <= 1'b0;
      unf_q <= 1'b0;
    end else begin
      for (int i = 0; i < NUM_CH; i++) begin
        wr_ptr_q[i] <= wr_ptr_d[i];
        rd_ptr_q[i] <= rd_ptr_d[i];
        cnt_q[i]    <= cnt_d[i];
      end
      ovf_q <= ovf_d;
      unf_q <= unf_d;
    end
  end

  // Storage is intentionally left out of reset.
  always_ff @(posedge clk) begin
    for (int i = 0; i < NUM_CH; i++) begin
      if (wr_en[i]) mem_q[i][wr_ptr_q[i]] <= bus.push_data;
    end
  end

  always_comb begin
    bus.out_data    = '0;
    bus.count       = '0;
    bus.out_valid   = '0;
    bus.almost_full = '0;
    bus.full        = '0;
    for (int i = 0; i < NUM_CH; i++) begin
      bus.out_valid[i]   = !empty_w[i];
      bus.full[i]        = full_w[i];
      bus.almost_full[i] = cnt_q[i] >= CNTW'(AFULL_THRESH);
      bus.count[i*CNTW +: CNTW] = cnt_q[i];
      if (!empty_w[i])
        bus.out_data[i*DATA_WIDTH +: DATA_WIDTH] =
          mem_q[i][rd_ptr_q[i]];
    end
  end

  assign bus.overflow_err  = ovf_q;
  assign bus.underflow_err = unf_q;
endmodule

// File: tb/tb_instruction_buffer_mc.sv
// Randomized + directed bench for instruction_buffer_mc against
// a queue-based reference model (4 ch, depth 4, afull 3).
module tb_instruction_buffer_mc;
  localparam int NCH = 4;
  localparam int DEP = 4;
  localparam int DW  = 32;
  localparam int AF  = 3;

  logic clk = 1'b0;
  logic rst_n;
  always #5 clk = ~clk;

  instruction_buffer_mc_if #(
    .NUM_CH(NCH), .DEPTH(DEP), .DATA_WIDTH(DW)
  ) bus ();

  instruction_buffer_mc #(
    .NUM_CH(NCH), .DEPTH(DEP), .DATA_WIDTH(DW),
    .AFULL_THRESH(AF)
  ) dut (
    .clk(clk),
    .rst_n(rst_n),
    .bus(bus)
  );

  logic [31:0] mq [NCH][$];
  logic        m_ovf;
  logic        m_unf;
  int          n_chk;
  int          n_pass;

  task automatic chk(input string tag, input logic [63:0] got,
                     input logic [63:0] exp);
    n_chk++;
    if (got === exp) n_pass++;
    else $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
  endtask

  task automatic model_clear();
    for (int i = 0; i < NCH; i++) mq[i].delete();
    m_ovf = 1'b0;
    m_unf = 1'b0;
  endtask

  task automatic check_state(input string tag);
    for (int i = 0; i < NCH; i++) begin
      int sz;
      sz = mq[i].size();
      chk($sformatf("%s.valid%0d", tag, i), 64'(bus.out_valid[i]),
          64'(sz != 0));
      chk($sformatf("%s.data%0d", tag, i),
          64'(bus.out_data[i*DW +: DW]),
          64'((sz != 0) ? mq[i][0] : 32'h0));
      chk($sformatf("%s.cnt%0d", tag, i),
          64'(bus.count[i*3 +: 3]), 64'(sz));
      chk($sformatf("%s.afull%0d", tag, i),
          64'(bus.almost_full[i]), 64'(sz >= AF));
      chk($sformatf("%s.full%0d", tag, i), 64'(bus.full[i]),
          64'(sz == DEP));
    end
    chk({tag, ".ovf"}, 64'(bus.overflow_err), 64'(m_ovf));
    chk({tag, ".unf"}, 64'(bus.underflow_err), 64'(m_unf));
  endtask

  // Called just after a rising edge; returns just after the next one.
  task automatic cycle(input logic pv, input logic [1:0] ch,
                       input logic [31:0] d, input logic [3:0] p,
                       input logic [3:0] f);
    bit pre_push;
    bit pre_pop [NCH];
    bus.push_valid = pv;
    bus.push_ch    = ch;
    bus.push_data  = d;
    bus.pop        = p;
    bus.flush      = f;
    @(negedge clk);
    chk("push_ready", 64'(bus.push_ready),
        64'(mq[ch].size() < DEP));
    pre_push = pv && !f[ch] && (mq[ch].size() < DEP);
    if (pv && !f[ch] && mq[ch].size() >= DEP) m_ovf = 1'b1;
    for (int i = 0; i < NCH; i++) begin
      pre_pop[i] = p[i] && !f[i] && mq[i].size() > 0;
      if (p[i] && !f[i] && mq[i].size() == 0) m_unf = 1'b1;
    end
    @(posedge clk);
    for (int i = 0; i < NCH; i++) begin
      if (f[i]) mq[i].delete();
      else if (pre_pop[i]) void'(mq[i].pop_front());
    end
    if (pre_push) mq[ch].push_back(d);
    #1;
    check_state("cyc");
  endtask

  task automatic idle();
    cycle(1'b0, 2'd0, 32'h0, 4'h0, 4'h0);
  endtask

  task automatic async_reset();
    bus.push_valid = 1'b0;
    bus.pop        = '0;
    bus.flush      = '0;
    rst_n = 1'b0;
    #2;
    model_clear();
    check_state("async_rst");
    chk("rst_ready", 64'(bus.push_ready), 64'(1));
    @(negedge clk);
    rst_n = 1'b1;
    @(posedge clk);
    #1;
  endtask

  initial begin
    n_chk  = 0;
    n_pass = 0;
    rst_n  = 1'b0;
    bus.push_valid = 1'b0;
    bus.push_ch    = '0;
    bus.push_data  = '0;
    bus.pop        = '0;
    bus.flush      = '0;
    model_clear();
    #12;
    check_state("reset");
    chk("reset_ready", 64'(bus.push_ready), 64'(1));
    @(negedge clk);
    rst_n = 1'b1;
    @(posedge clk);
    #1;

    // FIFO order on ch2
    for (int k = 0; k < 4; k++)
      cycle(1'b1, 2'd2, 32'hA0 + 32'(k), 4'h0, 4'h0);
    for (int k = 0; k < 4; k++) begin
      chk("fifo_head", 64'(bus.out_data[2*DW +: DW]),
          64'(32'hA0 + 32'(k)));
      cycle(1'b0, 2'd2, 32'h0, 4'b0100, 4'h0);
    end

    // full ch1, push with same-cycle pop rejected
    for (int k = 0; k < 4; k++)
      cycle(1'b1, 2'd1, 32'h10 + 32'(k), 4'h0, 4'h0);
    cycle(1'b1, 2'd1, 32'hFF, 4'b0010, 4'h0);
    chk("ovf_set", 64'(bus.overflow_err), 64'(1));
    for (int k = 0; k < 3; k++)
      cycle(1'b0, 2'd1, 32'h0, 4'b0010, 4'h0);

    // concurrent push/pop wrap on ch0
    cycle(1'b1, 2'd0, 32'hB8, 4'h0, 4'h0);
    cycle(1'b1, 2'd0, 32'hB9, 4'h0, 4'h0);
    for (int k = 0; k < 6; k++)
      cycle(1'b1, 2'd0, 32'hB0 + 32'(k), 4'b0001, 4'h0);

    // flush ch3 beats a push
    for (int k = 0; k < 3; k++)
      cycle(1'b1, 2'd3, 32'hC0 + 32'(k), 4'h0, 4'h0);
    cycle(1'b1, 2'd3, 32'hCF, 4'h0, 4'b1000);

    // underflow is sticky across flush
    cycle(1'b0, 2'd0, 32'h0, 4'h0, 4'b0001);
    cycle(1'b0, 2'd0, 32'h0, 4'b0001, 4'h0);
    chk("unf_set", 64'(bus.underflow_err), 64'(1));
    cycle(1'b0, 2'd0, 32'h0, 4'h0, 4'b1111);

    // async reset with every queue holding two entries
    for (int c = 0; c < NCH; c++)
      for (int k = 0; k < 2; k++)
        cycle(1'b1, 2'(c), 32'hD0 + 32'(c*2+k), 4'h0, 4'h0);
    async_reset();
    cycle(1'b1, 2'd1, 32'hE1, 4'h0, 4'h0);
    idle();

    // randomized traffic with an occasional reset
    for (int n = 0; n < 600; n++) begin
      logic [3:0] p, f;
      for (int i = 0; i < NCH; i++) begin
        p[i] = ($urandom_range(0, 99) < 30);
        f[i] = ($urandom_range(0, 99) < 3);
      end
      cycle(($urandom_range(0, 99) < 70), 2'($urandom_range(0, 3)),
            $urandom, p, f);
      if (n == 300) async_reset();
    end

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end
endmodule
